// File: rtl/ublock_pkg.sv
// Shared definitions for the uBlock round controller: FSM states,
// per-variant round counts and the default round-index width.
package ublock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NR_128_128 = 16;
  localparam int NR_128_256 = 24;
  localparam int NR_256_256 = 24;

  localparam int RIDX_W = 5;

endpackage

// File: rtl/ublock_round_ctrl.sv
// Iterative-round sequencer for the unmasked uBlock core. Accepts a
// block/key load, steps the round datapath NR times, fires the final
// whitening-key addition and holds the result until it is consumed.
// Carries control only; the 128-bit state lives in the datapath.
module ublock_round_ctrl
  import ublock_pkg::state_e, ublock_pkg::ST_IDLE, ublock_pkg::ST_ROUND,
         ublock_pkg::ST_FINAL, ublock_pkg::ST_DONE, ublock_pkg::NR_128_128;
#(
  parameter int NR     = NR_128_128,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              dec,
  output logic              ld_state,
  output logic              ld_key,
  output logic              rnd_en,
  output logic              ks_en,
  output logic              fin_en,
  output logic [RIDX_W-1:0] rnd_idx,
  output logic              dir,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
);

  // The round index must be able to hold NR-1.
  if ((2 ** RIDX_W) < NR) begin : g_bad_ridx_w
    $error("RIDX_W too narrow for NR");
  end

  localparam logic [RIDX_W-1:0] LastIdx = RIDX_W'(NR - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [RIDX_W-1:0] r_rnd_idx;
  logic              r_dir;
  logic              w_accept;
  logic              w_last_round;

  // A finished block can hand over to the next one in the same cycle the
  // consumer takes the result, giving back-to-back throughput.
  assign in_ready     = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept     = in_valid & in_ready;
  assign w_last_round = (r_rnd_idx == LastIdx);

  // The datapath samples plaintext and key on the same edge we accept.
  assign ld_state  = w_accept;
  assign ld_key    = w_accept;
  assign rnd_en    = (r_state == ST_ROUND);
  assign ks_en     = (r_state == ST_ROUND);
  assign fin_en    = (r_state == ST_FINAL);
  assign busy      = (r_state == ST_ROUND) | (r_state == ST_FINAL);
  assign out_valid = (r_state == ST_DONE);
  assign rnd_idx   = r_rnd_idx;
  assign dir       = r_dir;

  // Next-state decode for the block sequencer.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; a missing
    // branch would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ROUND;
      ST_ROUND: if (w_last_round) w_state_nxt = ST_FINAL;
      ST_FINAL: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept)       w_state_nxt = ST_ROUND;
        else if (out_ready) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, round index and latched direction; reset abandons any block.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the
    // same pre-edge values regardless of statement order.
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rnd_idx <= '0;
      r_dir     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rnd_idx <= '0;
        r_dir     <= dec;
      end else if ((r_state == ST_ROUND) && !w_last_round) begin
        r_rnd_idx <= r_rnd_idx + 1'b1;
      end
    end
  end

  // Loading, round and final-key strobes must never collide.
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({rnd_en, fin_en, ld_state}));

endmodule

// File: tb/tb_ublock_round_ctrl.sv
// Self-checking bench for ublock_round_ctrl. Two instances (16 and 24
// rounds) share the stimulus. Each has a reference model that tracks how
// many cycles have passed since the block was accepted and a scoreboard
// of predicted out_valid arrival cycles, checked by a separate monitor.
module tb_ublock_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic dec = 1'b0;
  logic out_ready = 1'b1;

  logic [1:0] w_in_ready, w_ld_state, w_ld_key, w_rnd_en, w_ks_en, w_fin_en;
  logic [1:0] w_dir, w_busy, w_out_valid;
  logic [4:0] w_rnd_idx [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ublock_round_ctrl #(.NR(16), .RIDX_W(5)) u_nr16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[0]),
    .dec(dec), .ld_state(w_ld_state[0]), .ld_key(w_ld_key[0]),
    .rnd_en(w_rnd_en[0]), .ks_en(w_ks_en[0]), .fin_en(w_fin_en[0]),
    .rnd_idx(w_rnd_idx[0]), .dir(w_dir[0]), .busy(w_busy[0]),
    .out_valid(w_out_valid[0]), .out_ready(out_ready)
  );

  ublock_round_ctrl #(.NR(24), .RIDX_W(5)) u_nr24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[1]),
    .dec(dec), .ld_state(w_ld_state[1]), .ld_key(w_ld_key[1]),
    .rnd_en(w_rnd_en[1]), .ks_en(w_ks_en[1]), .fin_en(w_fin_en[1]),
    .rnd_idx(w_rnd_idx[1]), .dir(w_dir[1]), .busy(w_busy[1]),
    .out_valid(w_out_valid[1]), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int   cyc;
    logic dir;
  } exp_t;

  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int NRG = (g == 0) ? 16 : 24;

    exp_t       sbq [$];
    int         k    = -1;    // cycles since accept; -1 when idle
    logic       mdir = 1'b0;
    logic [4:0] midx = '0;    // index held outside the round phase
    logic       seen = 1'b0;

    // Reference model: expected outputs from the block's age, then advance.
    always @(negedge clk) begin
      logic        in_rnd, in_fin, in_done, e_rdy, e_ld;
      logic [4:0]  e_idx;
      logic [14:0] e_vec, a_vec;
      in_rnd  = (k >= 1) && (k <= NRG);
      in_fin  = (k == NRG + 1);
      in_done = (k >= NRG + 2);
      e_rdy   = (k < 0) || (in_done && out_ready);
      e_ld    = in_valid && e_rdy;
      e_idx   = in_rnd ? 5'(k - 1) : midx;
      e_vec   = {e_rdy, e_ld, e_ld, in_rnd, in_rnd, in_fin, e_idx, mdir,
                 in_rnd | in_fin, in_done};
      a_vec   = {w_in_ready[g], w_ld_state[g], w_ld_key[g], w_rnd_en[g],
                 w_ks_en[g], w_fin_en[g], w_rnd_idx[g], w_dir[g], w_busy[g],
                 w_out_valid[g]};
      check($sformatf("outputs nr%0d cycle %0d", NRG, cyc), 32'(a_vec), 32'(e_vec));

      if (rst) begin
        k = -1; mdir = 1'b0; midx = '0;
      end else if (e_ld) begin
        k = 1; mdir = dec;
        sbq.push_back('{cyc + NRG + 2, dec});
      end else if (k >= 1 && k < NRG + 2) begin
        k++;
        if (k == NRG + 1) midx = 5'(NRG - 1);
      end else if (in_done && out_ready) begin
        k = -1;
      end
    end

    // Monitor: each new result must arrive exactly when predicted.
    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        sbq.delete();
        seen = 1'b0;
      end else begin
        if (w_out_valid[g] && !seen) begin
          if (sbq.size() == 0) begin
            check($sformatf("unexpected out_valid nr%0d cycle %0d", NRG, cyc), 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check($sformatf("out_valid cycle nr%0d", NRG), 32'(cyc), 32'(e.cyc));
            check($sformatf("result dir nr%0d cycle %0d", NRG, cyc), 32'(w_dir[g]), 32'(e.dir));
          end
          seen = 1'b1;
        end
        if (w_out_valid[g] && out_ready) seen = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(5);

    // Single block, consumer always ready.
    in_valid = 1'b1; dec = 1'b0;
    step(1);
    in_valid = 1'b0;
    step(30);

    // Consumer stalls well past completion of both instances.
    in_valid = 1'b1; dec = 1'b1; out_ready = 1'b0;
    step(1);
    in_valid = 1'b0;
    step(35);
    out_ready = 1'b1;
    step(5);

    // Back-to-back blocks with in_valid held high.
    in_valid = 1'b1; dec = 1'b0;
    step(80);
    in_valid = 1'b0;
    step(30);

    // Reset while rnd_idx==7, then a decrypt block runs to completion.
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    in_valid = 1'b1; dec = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(30);

    // Randomized traffic with stalls and rare resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 3);
      out_ready = ($urandom_range(0, 9) < 7);
      dec       = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 499) == 0);
      step(1);
    end

    // Drain: every predicted result must have been delivered.
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(40);
    check("scoreboard empty nr16", 32'(g_chk[0].sbq.size()), 32'd0);
    check("scoreboard empty nr24", 32'(g_chk[1].sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ublock_round_ctrl.md
Name: ublock_round_ctrl

Overview:
- Iterative-round sequencer for the unmasked uBlock encryption core.
- Accepts a block/key load via a valid/ready handshake and drives load and enable strobes into the round datapath (S-box layer of nor/xnor cells, linear layer, key schedule).
- Steps the round index, fires the final whitening-key addition, then presents the result with valid/ready back-pressure.
- Pure control: no 128-bit data passes through this block.

Parameters:
- NR, 16, number of full rounds (16 for uBlock-128/128; 24 for the 128/256 and 256/256 variants).
- RIDX_W, 5, width of the round index; must satisfy 2**RIDX_W >= NR.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key present on the datapath inputs.
- in_ready  output  1  controller can accept a new block.
- dec  input  1  direction for this block (0 = encrypt, 1 = decrypt); sampled on the accept cycle.
- ld_state  output  1  datapath captures plaintext into the state register.
- ld_key  output  1  key schedule captures the master key.
- rnd_en  output  1  state register takes the round-function output.
- ks_en  output  1  key schedule advances one step.
- fin_en  output  1  state register takes state XOR final round key.
- rnd_idx  output  RIDX_W  current round number, 0..NR-1; drives round-constant selection.
- dir  output  1  latched dec for the block in flight.
- busy  output  1  a block is being processed (ROUND or FINAL).
- out_valid  output  1  ciphertext on the datapath output is valid.
- out_ready  input  1  consumer accepts the ciphertext.

Behaviour:
- States: IDLE, ROUND, FINAL, DONE. Held in a state register.
- Reset (synchronous, rst=1 at an edge):
  - state goes to IDLE; rnd_idx=0; dir=0.
  - All strobes 0, out_valid=0, busy=0, in_ready=1 after the edge.
  - Reset mid-block abandons it: no out_valid is ever issued for that block.
- accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready).
- ld_state = ld_key = accept. These are combinational; the datapath samples on the same edge. dir is loaded from dec on accept.
- On accept, the next state is ROUND with rnd_idx=0.
- ROUND:
  - rnd_en=ks_en=1 every cycle.
  - At rnd_idx==NR-1: next state FINAL, rnd_idx stays at NR-1.
  - Otherwise rnd_idx increments by 1. It never wraps past NR-1.
- FINAL: fin_en=1 for exactly one cycle, then DONE.
- DONE:
  - out_valid=1 and holds until out_ready.
  - If out_ready & in_valid: accept the new block (back-to-back) and go to ROUND with rnd_idx=0.
  - If out_ready & !in_valid: go to IDLE.
  - If !out_ready: stay in DONE with all strobes 0.
- busy=1 in ROUND and FINAL only.
- Latency: accept at cycle t, rounds at t+1..t+NR, FINAL at t+NR+1, out_valid from t+NR+2.
- Throughput: one block per NR+2 cycles when out_ready is held high.
- Strobe exclusivity: rnd_en, fin_en and ld_state are never high in the same cycle. Assertion required.
- in_valid in ROUND or FINAL is ignored; the input is not consumed.
- dec has no effect on sequencing. It only selects key-schedule direction through dir.

Decomposition:
- Shared package ublock_pkg holds:
  - state enum (IDLE/ROUND/FINAL/DONE).
  - variant round counts NR_128_128=16, NR_128_256=24, NR_256_256=24.
  - RIDX_W.
- Single module. The round counter is inline; no sub-module is warranted.

Test Plan:
- rst=1 for 2 cycles then 0 -> in_ready=1; out_valid=0, busy=0, rnd_idx=0, all strobes 0.
- NR=16, in_valid pulse at t=10, out_ready=1 ->
  - ld_state/ld_key high at t=10 only.
  - rnd_en high for t=11..26, with rnd_idx 0..15.
  - fin_en at t=27; out_valid at t=28 for one cycle.
- out_ready=0 for 5 cycles after out_valid -> out_valid held 6 cycles, no strobes, in_ready=0; then release -> IDLE.
- in_valid held high, out_ready=1 -> accepts at t, t+18, t+36; ld_state coincides with out_valid & out_ready.
- rst=1 at rnd_idx=7 -> next cycle IDLE, rnd_idx=0, no out_valid; a following block completes normally with dir re-latched (dec=1 -> dir=1).
- NR=24 -> rnd_idx reaches 23; out_valid 26 cycles after accept.
